// File: rtl/mc_core.sv
// mc_core: multi-cycle 16-bit-instruction processor.
// Writable instruction memory, 4-entry register file, ALU with flags,
// synchronous data memory and a FETCH/EXEC/MEM sequencer with start/halt,
// single-step pause and sticky illegal-opcode detection.
module mc_core #(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [15:0]        prog_data,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic [1:0]         read_sel,
  output logic [DATA_W-1:0]  read_data,
  output logic [IMEM_AW-1:0] pc_out,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               is_zero,
  output logic               is_sign,
  output logic               is_ovf,
  output logic [7:0]         led
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_PAUSE = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_ADDI = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_MOV  = 5'b01000;
  localparam logic [4:0] OP_LDI  = 5'b01001;
  localparam logic [4:0] OP_LD   = 5'b01010;
  localparam logic [4:0] OP_ST   = 5'b01011;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_JZ   = 5'b01101;
  localparam logic [4:0] OP_JNZ  = 5'b01110;
  localparam logic [4:0] OP_JL   = 5'b01111;
  localparam logic [4:0] OP_JG   = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [IMEM_AW-1:0] PC_ONE = IMEM_AW'(1'b1);

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] r);
    return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Signed overflow of a - b: operands differ in sign, result sign differs from a.
  function automatic logic sub_ovf(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] r);
    return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Storage
  logic [15:0]        imem [2**IMEM_AW];
  logic [DATA_W-1:0]  dmem [2**DMEM_AW];
  logic [DATA_W-1:0]  regs [4];

  // Sequencer state
  state_t             state;
  logic [IMEM_AW-1:0] pc;
  logic [15:0]        ir;
  logic [DATA_W-1:0]  dmem_q;
  logic               zero_f;
  logic               sign_f;
  logic               ovf_f;
  logic               illegal_f;
  logic               busy_r;
  logic               halted_r;

  // Decoded instruction fields
  logic [4:0]         opcode;
  logic [1:0]         rd_idx;
  logic [1:0]         rs_idx;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  imm_ext;
  logic [IMEM_AW-1:0] jmp_tgt;
  logic [DMEM_AW-1:0] dmem_addr;

  // Execute-stage control
  logic [DATA_W-1:0]  alu_res;
  logic               alu_ovf;
  logic               reg_we;
  logic               flag_we;
  logic               take_jump;
  logic               is_ld;
  logic               is_st;
  logic               is_halt;
  logic               is_bad;
  logic               imem_we;
  logic               dmem_we;
  state_t             next_run;

  assign opcode    = ir[15:11];
  assign rd_idx    = ir[10:9];
  assign rs_idx    = ir[8:7];
  assign op_a      = regs[rd_idx];
  assign op_b      = regs[rs_idx];
  assign imm_ext   = DATA_W'(ir[7:0]);
  assign jmp_tgt   = IMEM_AW'(ir[7:0]);
  assign dmem_addr = DMEM_AW'(op_b);

  // Programming is locked out whenever an instruction sequence is in flight.
  assign imem_we = prog_we && ((state == S_IDLE) || (state == S_HALT));
  assign dmem_we = (state == S_EXEC) && is_st;

  // Where to go after a completed instruction.
  assign next_run = step_mode ? S_PAUSE : S_FETCH;

  // Decode the held instruction and compute ALU result, flags and control.
  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    reg_we    = 1'b0;
    flag_we   = 1'b0;
    take_jump = 1'b0;
    is_ld     = 1'b0;
    is_st     = 1'b0;
    is_halt   = 1'b0;
    is_bad    = 1'b0;
    case (opcode)
      OP_NOP: begin
        reg_we = 1'b0;
      end
      OP_ADD: begin
        alu_res = op_a + op_b;
        alu_ovf = add_ovf(op_a, op_b, op_a + op_b);
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_ovf = sub_ovf(op_a, op_b, op_a - op_b);
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_AND: begin
        alu_res = op_a & op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_OR: begin
        alu_res = op_a | op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_XOR: begin
        alu_res = op_a ^ op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_ADDI: begin
        alu_res = op_a + imm_ext;
        alu_ovf = add_ovf(op_a, imm_ext, op_a + imm_ext);
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SUBI: begin
        alu_res = op_a - imm_ext;
        alu_ovf = sub_ovf(op_a, imm_ext, op_a - imm_ext);
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_MOV: begin
        alu_res = op_b;
        reg_we  = 1'b1;
      end
      OP_LDI: begin
        alu_res = imm_ext;
        reg_we  = 1'b1;
      end
      OP_LD:   is_ld     = 1'b1;
      OP_ST:   is_st     = 1'b1;
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = zero_f;
      OP_JNZ:  take_jump = !zero_f;
      OP_JL:   take_jump = sign_f;
      OP_JG:   take_jump = !sign_f && !zero_f;
      OP_HALT: is_halt   = 1'b1;
      default: is_bad    = 1'b1;
    endcase
  end

  // Instruction memory programming port (contents survive reset).
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

  // Data memory: store in EXEC, registered read consumed in MEM.
  always_ff @(posedge clk) begin
    if (dmem_we) begin
      dmem[dmem_addr] <= op_a;
    end
    dmem_q <= dmem[dmem_addr];
  end

  // Sequencer: FSM, pc, instruction register, register file, flags and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= 16'h0000;
      zero_f    <= 1'b0;
      sign_f    <= 1'b0;
      ovf_f     <= 1'b0;
      illegal_f <= 1'b0;
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= '0;
            busy_r   <= 1'b1;
            halted_r <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (reg_we) begin
            regs[rd_idx] <= alu_res;
          end
          if (flag_we) begin
            zero_f <= (alu_res == '0);
            sign_f <= alu_res[DATA_W-1];
            ovf_f  <= alu_ovf;
          end
          if (is_bad) begin
            illegal_f <= 1'b1;
          end
          if (is_ld) begin
            state <= S_MEM;
          end else if (is_halt) begin
            state    <= S_HALT;
            busy_r   <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            pc    <= take_jump ? jmp_tgt : (pc + PC_ONE);
            state <= next_run;
          end
        end
        S_MEM: begin
          regs[rd_idx] <= dmem_q;
          pc           <= pc + PC_ONE;
          state        <= next_run;
        end
        S_PAUSE: begin
          if (step) begin
            state <= S_FETCH;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy_r   <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign read_data = regs[read_sel];
  assign led       = regs[3][7:0];
  assign pc_out    = pc;
  assign busy      = busy_r;
  assign halted    = halted_r;
  assign illegal   = illegal_f;
  assign is_zero   = zero_f;
  assign is_sign   = sign_f;
  assign is_ovf    = ovf_f;

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: scoreboard bench for mc_core. Programs are run through an
// instruction-level interpreter; the expected architectural state at HALT
// is queued, and a monitor compares it when the core reports halted.
module tb_mc_core;

  localparam int NOP = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, XOR_ = 5;
  localparam int ADDI = 6, SUBI = 7, MOV = 8, LDI = 9, LD = 10, ST = 11;
  localparam int JMP = 12, JZ = 13, JNZ = 14, JL = 15, JG = 16, HLT = 31;

  typedef struct packed {
    logic [3:0][7:0] r;
    logic            z;
    logic            s;
    logic            o;
    logic            ill;
    logic [7:0]      pc;
    logic [31:0]     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'h00;
  logic [15:0] prog_data = 16'h0000;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [1:0]  read_sel = 2'd0;
  logic [7:0]  read_data;
  logic [7:0]  pc_out;
  logic        busy, halted, illegal, is_zero, is_sign, is_ovf;
  logic [7:0]  led;

  mc_core dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .step_mode(step_mode), .step(step),
    .read_sel(read_sel), .read_data(read_data), .pc_out(pc_out), .busy(busy),
    .halted(halted), .illegal(illegal), .is_zero(is_zero), .is_sign(is_sign),
    .is_ovf(is_ovf), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  int   t_start = 0;
  exp_t exp_q[$];

  // Reference machine state
  logic [15:0] m_imem[256];
  int          m_regs[4];
  int          m_dmem[256];
  bit          m_z, m_s, m_o, m_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ins_r(input int op, input int rd, input int rs);
    logic [4:0] o; logic [1:0] d; logic [1:0] s;
    o = op[4:0]; d = rd[1:0]; s = rs[1:0];
    return {o, d, s, 7'b0000000};
  endfunction

  function automatic logic [15:0] ins_i(input int op, input int rd, input int imm);
    logic [4:0] o; logic [1:0] d; logic [7:0] i;
    o = op[4:0]; d = rd[1:0]; i = imm[7:0];
    return {o, d, 1'b0, i};
  endfunction

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_z = 0; m_s = 0; m_o = 0; m_ill = 0;
  endtask

  // Instruction-level interpreter: runs from pc=0 to HALT.
  task automatic model_run(output exp_t e);
    int pc, cy, n, op, rd, rs, imm, a, b, y, full, res;
    bit done, jumped, taken;
    logic [15:0] w;
    pc = 0; cy = 0; n = 0; done = 0;
    while (!done && n < 20000) begin
      w = m_imem[pc];
      op = int'(w[15:11]); rd = int'(w[10:9]); rs = int'(w[8:7]); imm = int'(w[7:0]);
      a = m_regs[rd]; b = m_regs[rs];
      cy += 2; n++; jumped = 0; taken = 0;
      case (op)
        ADD, SUB, ADDI, SUBI: begin
          y = (op == ADD || op == SUB) ? b : imm;
          if (op == ADD || op == ADDI) begin
            full = sx(a) + sx(y); res = (a + y) % 256;
          end else begin
            full = sx(a) - sx(y); res = (a - y + 256) % 256;
          end
          m_regs[rd] = res; m_z = (res == 0); m_s = (res >= 128);
          m_o = (full > 127 || full < -128);
        end
        AND_, OR_, XOR_: begin
          res = (op == AND_) ? (a & b) : (op == OR_) ? (a | b) : (a ^ b);
          m_regs[rd] = res; m_z = (res == 0); m_s = (res >= 128); m_o = 0;
        end
        MOV: m_regs[rd] = b;
        LDI: m_regs[rd] = imm;
        LD:  begin m_regs[rd] = m_dmem[b]; cy += 1; end
        ST:  m_dmem[b] = a;
        JMP, JZ, JNZ, JL, JG: begin
          taken = (op == JMP) || (op == JZ && m_z) || (op == JNZ && !m_z) ||
                  (op == JL && m_s) || (op == JG && !m_s && !m_z);
          if (taken) begin pc = imm; jumped = 1; end
        end
        HLT: done = 1;
        NOP: ;
        default: m_ill = 1;
      endcase
      if (!done && !jumped) pc = (pc + 1) % 256;
    end
    for (int i = 0; i < 4; i++) e.r[i] = 8'(m_regs[i]);
    e.z = m_z; e.s = m_s; e.o = m_o; e.ill = m_ill;
    e.pc = 8'(pc); e.cyc = 32'(cy);
  endtask

  task automatic push_expect(input bit check_cyc);
    exp_t e;
    model_run(e);
    if (!check_cyc) e.cyc = 32'hFFFF_FFFF;
    exp_q.push_back(e);
  endtask

  task automatic load(input int addr, input logic [15:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr[7:0]; prog_data = w;
    m_imem[addr] = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 t_start = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  // Last program word written in the very cycle that start is sampled.
  task automatic start_with_write(input int addr, input logic [15:0] w);
    m_imem[addr] = w;
    push_expect(1'b1);
    @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = addr[7:0]; prog_data = w;
    @(posedge clk); #1 t_start = cyc;
    @(negedge clk); start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 4000) begin @(negedge clk); n++; end
    chk("halt_reached", {31'd0, halted}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_prog();
    push_expect(1'b1);
    pulse_start();
    wait_halt();
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: on each rising halted, pop the expected state and compare.
  initial begin
    bit   prev, h;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      h = halted;
      if (h && !prev) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_halt: got halt at pc %0h expected none", pc_out);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 4; i++) begin
            read_sel = 2'(i);
            #1 chk($sformatf("reg_r%0d", i), {24'd0, read_data}, {24'd0, e.r[i]});
          end
          chk("zero_flag", {31'd0, is_zero}, {31'd0, e.z});
          chk("sign_flag", {31'd0, is_sign}, {31'd0, e.s});
          chk("ovf_flag", {31'd0, is_ovf}, {31'd0, e.o});
          chk("illegal_flag", {31'd0, illegal}, {31'd0, e.ill});
          chk("halt_pc", {24'd0, pc_out}, {24'd0, e.pc});
          chk("led_r3", {24'd0, led}, {24'd0, e.r[3]});
          chk("busy_at_halt", {31'd0, busy}, 32'd0);
          if (e.cyc != 32'hFFFF_FFFF) chk("cycles", 32'(cyc - t_start), e.cyc);
        end
      end
      prev = h;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int L, op, r;
    logic [15:0] w;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pc", {24'd0, pc_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_flags", {29'd0, is_zero, is_sign, is_ovf}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    rst_n = 1'b1;

    // Basic add; word 0 written together with start.
    load(1, ins_i(LDI, 1, 3));
    load(2, ins_r(ADD, 0, 1));
    load(3, ins_r(HLT, 0, 0));
    start_with_write(0, ins_i(LDI, 0, 5));
    wait_halt();

    // Fill data memory: dmem[i] = i for all 256 addresses.
    load(0, ins_i(LDI, 0, 0));
    load(1, ins_r(ST, 0, 0));
    load(2, ins_i(ADDI, 0, 1));
    load(3, ins_i(JNZ, 0, 1));
    load(4, ins_r(HLT, 0, 0));
    run_prog();

    // Signed overflow on 0x7F+1, then back to zero.
    load(0, ins_i(LDI, 0, 8'h7F));
    load(1, ins_i(ADDI, 0, 1));
    load(2, ins_r(HLT, 0, 0));
    run_prog();
    load(2, ins_i(SUBI, 0, 8'h80));
    load(3, ins_r(HLT, 0, 0));
    run_prog();

    // Store then load through a register address.
    load(0, ins_i(LDI, 2, 8'h10));
    load(1, ins_i(LDI, 3, 8'hA5));
    load(2, ins_r(ST, 3, 2));
    load(3, ins_r(LD, 1, 2));
    load(4, ins_r(HLT, 0, 0));
    run_prog();

    // Countdown loop.
    load(0, ins_i(LDI, 0, 3));
    load(1, ins_i(SUBI, 0, 1));
    load(2, ins_i(JNZ, 0, 1));
    load(3, ins_r(HLT, 0, 0));
    run_prog();

    // Programming attempts while busy must be dropped; re-run shows imem intact.
    load(0, ins_i(LDI, 0, 8'h11));
    load(1, ins_r(NOP, 0, 0));
    load(2, ins_r(NOP, 0, 0));
    load(3, ins_r(NOP, 0, 0));
    load(4, ins_r(HLT, 0, 0));
    push_expect(1'b1);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 8'h00; prog_data = ins_i(LDI, 0, 8'h99);
    end
    @(negedge clk); prog_we = 1'b0;
    wait_halt();
    run_prog();

    // Random forward-branching programs.
    for (int k = 0; k < 25; k++) begin
      if (k % 8 == 7) do_reset();
      L = $urandom_range(14, 8);
      for (int i = 0; i < L - 1; i++) begin
        r = $urandom_range(99, 0);
        op = (r < 8) ? $urandom_range(30, 17) : $urandom_range(16, 0);
        if (op >= JMP && op <= JG)
          w = ins_i(op, 0, $urandom_range(L - 1, i + 1));
        else if (op == ADDI || op == SUBI || op == LDI)
          w = ins_i(op, $urandom_range(3, 0), $urandom_range(255, 0));
        else
          w = ins_r(op, $urandom_range(3, 0), $urandom_range(3, 0));
        load(i, w);
      end
      load(L - 1, ins_r(HLT, 0, 0));
      run_prog();
    end

    // Single-step mode with an illegal opcode in the middle.
    do_reset();
    load(0, ins_i(LDI, 3, 8'h5A));
    load(1, 16'hAE00);
    load(2, ins_i(LDI, 3, 8'h3C));
    load(3, ins_r(HLT, 0, 0));
    push_expect(1'b0);
    step_mode = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("pause_pc", {24'd0, pc_out}, 32'd1);
    chk("pause_illegal", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause_hold_pc", {24'd0, pc_out}, 32'd1);
      chk("pause_busy", {31'd0, busy}, 32'd1);
    end
    do_step();
    chk("step1_pc", {24'd0, pc_out}, 32'd2);
    chk("step1_illegal", {31'd0, illegal}, 32'd1);
    chk("step1_led", {24'd0, led}, 32'h5A);
    do_step();
    chk("step2_pc", {24'd0, pc_out}, 32'd3);
    chk("step2_led", {24'd0, led}, 32'h3C);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_halt();
    step_mode = 1'b0;

    // Reset during the MEM state of a load.
    load(0, ins_i(LDI, 3, 8'h55));
    load(1, ins_i(LDI, 2, 8'h10));
    load(2, ins_r(LD, 3, 2));
    load(3, ins_r(HLT, 0, 0));
    pulse_start();
    repeat (6) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    chk("abort_led_before", {24'd0, led}, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("abort_pc", {24'd0, pc_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_led", {24'd0, led}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("abort_idle_pc", {24'd0, pc_out}, 32'd0);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_idle_halted", {31'd0, halted}, 32'd0);
    run_prog();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
